wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DATA_W, 16, register data width.
REQ-002 Parameter ADDR_W, 4, register address width.
REQ-003 Parameter STARVE_LIMIT, 4, number of consecutive blocked LLU cycles before a forced grant; legal range 2..15.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 wb_reg_write, wb_mem_to_reg  in  1 each  MEM/WB pipeline write request and result select.
REQ-007 wb_alu_result, wb_mem_data  in  DATA_W each  MEM/WB pipeline candidate data.
REQ-008 wb_rd  in  ADDR_W  MEM/WB pipeline destination register.
REQ-009 lu_valid  in  1  long-latency unit (mul/div) result valid.
REQ-010 lu_rd, lu_data  in  ADDR_W, DATA_W  long-latency unit destination and result.
REQ-011 lu_ready  out  1  LLU result accepted this cycle.
REQ-012 rf_we, rf_waddr, rf_wdata  out  1, ADDR_W, DATA_W  register-file write port.
REQ-013 pipe_stall  out  1  request that the pipeline insert one MEM/WB bubble.
REQ-014 protocol_err  out  1  sticky pipeline-contract violation flag.

Function
REQ-015 pipe_req = wb_reg_write && wb_rd != 0; a pipeline write to r0 shall be dropped (rf_we=0) and shall not block the LLU.
REQ-016 The pipeline shall have priority: if pipe_req=1, then rf_we=1, rf_waddr=wb_rd, and rf_wdata=wb_mem_to_reg ? wb_mem_data : wb_alu_result, all combinational in the same cycle.
REQ-017 If pipe_req=0 and lu_valid=1, then lu_ready=1, rf_we=(lu_rd!=0), rf_waddr=lu_rd, and rf_wdata=lu_data in the same cycle; an LLU result to r0 shall be consumed without being written.
REQ-018 An LLU handshake is lu_valid && lu_ready; lu_rd and lu_data shall be held stable by the LLU while lu_valid=1 and lu_ready=0.
REQ-019 If neither requester is active, then rf_we=0, rf_waddr=0, and rf_wdata=0.
REQ-020 FSM states: IDLE, WAIT, STALL, GRANT.
REQ-021 IDLE->WAIT when lu_valid && pipe_req; otherwise stay in IDLE.
REQ-022 In WAIT, a blocked-cycle counter shall increment each cycle lu_valid && pipe_req holds; on an LLU handshake or lu_valid=0 the FSM shall go to IDLE and the counter shall clear.
REQ-023 WAIT->STALL on the edge at which the counter reaches STARVE_LIMIT-1 while the LLU is still blocked.
REQ-024 In STALL, pipe_stall=1 (registered, exactly one cycle) and normal priority applies; STALL->GRANT unconditionally.
REQ-025 In GRANT, the LLU shall be granted regardless of pipe_req; the exit is GRANT->IDLE on an LLU handshake or when lu_valid=0.
REQ-026 If pipe_req=1 in GRANT (bubble contract broken), the pipeline shall still win, protocol_err shall set and remain set until reset, and the FSM shall stay in GRANT.
REQ-027 The counter shall be 4 bits wide and saturating, and shall clear whenever the FSM enters IDLE.

Reset
REQ-028 While rst_n=0: FSM=IDLE, counter=0, pipe_stall=0, and protocol_err=0.
REQ-029 While rst_n=0, rf_we=0 and lu_ready=0 regardless of inputs.
REQ-030 A reset asserted in STALL or GRANT shall abandon the forced grant; after release, behaviour shall be that of REQ-021.

Configuration
REQ-031 Macro WB_STARVE_GUARD_EN: when defined, REQ-020..REQ-027 shall apply in full.
REQ-032 When WB_STARVE_GUARD_EN is undefined: no FSM or counter shall be present, arbitration shall be pure fixed priority per REQ-016/017, pipe_stall shall be tied 0, and protocol_err shall be tied 0.

Structure
REQ-033 A shared package shall hold the FSM state encoding (2-bit: IDLE=0, WAIT=1, STALL=2, GRANT=3) and the default DATA_W/ADDR_W constants.
REQ-034 There shall be one sub-module, wb_starve_guard (FSM plus counter, emitting force_grant and pipe_stall), instantiated only under WB_STARVE_GUARD_EN.

Verification
REQ-035 Pipeline only: wb_reg_write=1, wb_rd=3, wb_mem_to_reg=1, mem_data=0xBEEF, alu=0x1234 -> rf_we=1, waddr=3, wdata=0xBEEF in the same cycle.
REQ-036 Simultaneous requests: pipeline rd=5, LLU rd=7 data=0x00AA -> pipeline written and lu_ready=0; next cycle wb_reg_write=0 -> lu_ready=1, waddr=7, wdata=0x00AA.
REQ-037 Starvation with STARVE_LIMIT=4: pipe_req held high and lu_valid held high -> pipe_stall=1 for exactly one cycle 4 cycles after lu_valid rises; the bench drives a bubble next cycle -> lu_ready=1 in GRANT; FSM returns to IDLE.
REQ-038 Contract violation: in GRANT, drive pipe_req=1 -> pipeline written, lu_ready=0, protocol_err=1 and still 1 after 10 further cycles.
REQ-039 r0 handling: pipeline wb_rd=0 with LLU valid rd=2 -> rf_we=1 with waddr=2 (LLU wins); LLU rd=0 alone -> lu_ready=1, rf_we=0.
REQ-040 Reset mid-GRANT: rst_n low for 1 cycle -> pipe_stall=0, protocol_err=0, FSM=IDLE; with the macro undefined, the REQ-037 stimulus shall never assert pipe_stall.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter_pkg
//  Purpose  : Shared definitions for the write-back port arbiter: default
//             data/address widths and the starvation-guard FSM encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package wb_port_arbiter_pkg;

    localparam int c_DATA_W_DEFAULT = 16;
    localparam int c_ADDR_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_STALL = 2'd2,
        S_GRANT = 2'd3
    } guard_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_starve_guard.sv
`default_nettype none
// ============================================================================
//  Module   : wb_starve_guard
//  Purpose  : Watches the long-latency unit being blocked by the pipeline.
//             After STARVE_LIMIT-1 consecutive blocked cycles in WAIT it
//             requests one pipeline bubble (pipe_stall, one registered cycle)
//             and then holds a forced grant until the LLU is served or drops.
//  Ports    : clk, rst_n        - clock, asynchronous active-low reset
//             pipe_req          - pipeline has a real (non-r0) write
//             lu_valid/lu_ready - LLU handshake as seen at the write port
//             force_grant       - FSM is in GRANT
//             pipe_stall        - one-cycle bubble request
//  Revision : 1.0 - initial release
// ============================================================================
module wb_starve_guard
    import wb_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pipe_req,
    input  logic lu_valid,
    input  logic lu_ready,
    output logic force_grant,
    output logic pipe_stall
);

    localparam logic [3:0] c_STALL_AT = 4'(STARVE_LIMIT - 1);

    guard_state_t r_state;
    guard_state_t w_state_next;
    logic [3:0]   r_cnt;
    logic [3:0]   w_cnt_next;
    logic [3:0]   w_cnt_inc;
    logic         r_pipe_stall;
    logic         w_blocked;
    logic         w_handshake;

    assign w_blocked   = lu_valid && pipe_req;
    assign w_handshake = lu_valid && lu_ready;
    // Saturating increment keeps the counter pinned at 15 instead of wrapping.
    assign w_cnt_inc   = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = 4'd0;
                if (w_blocked) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_blocked) begin
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc >= c_STALL_AT) begin
                        w_state_next = S_STALL;
                    end
                end else begin
                    // Either the LLU was served or it withdrew.
                    w_state_next = S_IDLE;
                    w_cnt_next   = 4'd0;
                end
            end
            S_STALL: begin
                w_state_next = S_GRANT;
            end
            S_GRANT: begin
                // A pipeline write here blocks the handshake, so the FSM
                // simply stays put until the bubble actually arrives.
                if (w_handshake || !lu_valid) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = 4'd0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_pipe_stall <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_pipe_stall <= (w_state_next == S_STALL);
        end
    end

    assign force_grant = (r_state == S_GRANT);
    assign pipe_stall  = r_pipe_stall;

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter
//  Purpose  : Arbitrates the single register-file write port between the
//             MEM/WB pipeline stage (fixed priority) and a long-latency unit.
//             Build option WB_STARVE_GUARD_EN adds a starvation guard that
//             requests a pipeline bubble and flags broken bubble contracts.
//  Ports    : clk, rst_n                      - clock, async active-low reset
//             wb_reg_write, wb_mem_to_reg,
//             wb_alu_result, wb_mem_data, wb_rd - MEM/WB write request
//             lu_valid, lu_rd, lu_data, lu_ready - LLU result handshake
//             rf_we, rf_waddr, rf_wdata        - register-file write port
//             pipe_stall                       - one-cycle bubble request
//             protocol_err                     - sticky contract violation
//  Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W       = c_DATA_W_DEFAULT,
    parameter int ADDR_W       = c_ADDR_W_DEFAULT,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_reg_write,
    input  logic              wb_mem_to_reg,
    input  logic [DATA_W-1:0] wb_alu_result,
    input  logic [DATA_W-1:0] wb_mem_data,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_rd,
    input  logic [DATA_W-1:0] lu_data,
    output logic              lu_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pipe_stall,
    output logic              protocol_err
);

    logic              w_pipe_req;
    logic              w_lu_win;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    // Writes to r0 are architectural no-ops, so they never claim the port.
    assign w_pipe_req = wb_reg_write && (wb_rd != '0);
    assign w_lu_win   = lu_valid && !w_pipe_req;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (w_pipe_req) begin
            w_we    = 1'b1;
            w_waddr = wb_rd;
            w_wdata = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
        end else if (lu_valid) begin
            // An LLU result to r0 is still accepted, just not written.
            w_we    = (lu_rd != '0);
            w_waddr = lu_rd;
            w_wdata = lu_data;
        end
    end

    // Reset gates the write enable and handshake directly so nothing leaks
    // into the register file or the LLU while rst_n is low.
    assign rf_we    = rst_n && w_we;
    assign lu_ready = rst_n && w_lu_win;
    assign rf_waddr = w_waddr;
    assign rf_wdata = w_wdata;

`ifdef WB_STARVE_GUARD_EN
    logic w_force_grant;
    logic r_protocol_err;

    wb_starve_guard #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_guard (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_req    (w_pipe_req),
        .lu_valid    (lu_valid),
        .lu_ready    (w_lu_win),
        .force_grant (w_force_grant),
        .pipe_stall  (pipe_stall)
    );

    // The pipeline keeps priority even during a forced grant; the grant is
    // realised by the bubble, so a pipeline write here is a contract breach.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_protocol_err <= 1'b0;
        end else if (w_force_grant && w_pipe_req) begin
            r_protocol_err <= 1'b1;
        end
    end

    assign protocol_err = r_protocol_err;
`else
    logic w_unused;

    // Pure fixed priority: no sequential state, so clk and the starvation
    // limit are intentionally unused here.
    assign w_unused     = ^{clk, 4'(STARVE_LIMIT)};
    assign pipe_stall   = 1'b0;
    assign protocol_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_port_arbiter
//  Purpose  : Directed self-checking bench for wb_port_arbiter. Expected
//             port values are queued when a step is driven and compared when
//             the cycle is sampled. Honours WB_STARVE_GUARD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

`ifdef WB_STARVE_GUARD_EN
    localparam bit c_GUARD = 1'b1;
`else
    localparam bit c_GUARD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [15:0] wb_alu_result;
    logic [15:0] wb_mem_data;
    logic [3:0]  wb_rd;
    logic        lu_valid;
    logic [3:0]  lu_rd;
    logic [15:0] lu_data;
    logic        lu_ready;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        pipe_stall;
    logic        protocol_err;

    wb_port_arbiter #(
        .DATA_W       (16),
        .ADDR_W       (4),
        .STARVE_LIMIT (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_alu_result (wb_alu_result),
        .wb_mem_data   (wb_mem_data),
        .wb_rd         (wb_rd),
        .lu_valid      (lu_valid),
        .lu_rd         (lu_rd),
        .lu_data       (lu_data),
        .lu_ready      (lu_ready),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .pipe_stall    (pipe_stall),
        .protocol_err  (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        we;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        logic        lr;
        logic        ps;
        logic        pe;
        bit          chk_data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    logic exp_perr = 1'b0;

    task automatic set_pipe(input logic we, input logic [3:0] rd, input logic m2r,
                            input logic [15:0] alu, input logic [15:0] mem);
        wb_reg_write  = we;
        wb_rd         = rd;
        wb_mem_to_reg = m2r;
        wb_alu_result = alu;
        wb_mem_data   = mem;
    endtask

    task automatic set_lu(input logic v, input logic [3:0] rd, input logic [15:0] d);
        lu_valid = v;
        lu_rd    = rd;
        lu_data  = d;
    endtask

    // Queue the expectation for the current cycle, sample mid-cycle, compare,
    // then advance to just after the next rising edge.
    task automatic step(input string tag, input logic we, input logic [3:0] waddr,
                        input logic [15:0] wdata, input logic lr, input logic ps,
                        input bit chk_data);
        exp_t e;
        e.tag = tag; e.we = we; e.waddr = waddr; e.wdata = wdata;
        e.lr = lr; e.ps = ps; e.pe = exp_perr; e.chk_data = chk_data;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        assert (rf_we === e.we) else begin
            n_err++;
            $error("FAIL %s rf_we observed %0b expected %0b", e.tag, rf_we, e.we);
        end
        n_checks++;
        assert (lu_ready === e.lr) else begin
            n_err++;
            $error("FAIL %s lu_ready observed %0b expected %0b", e.tag, lu_ready, e.lr);
        end
        n_checks++;
        assert (pipe_stall === e.ps) else begin
            n_err++;
            $error("FAIL %s pipe_stall observed %0b expected %0b", e.tag, pipe_stall, e.ps);
        end
        n_checks++;
        assert (protocol_err === e.pe) else begin
            n_err++;
            $error("FAIL %s protocol_err observed %0b expected %0b", e.tag, protocol_err, e.pe);
        end
        if (e.chk_data) begin
            n_checks++;
            assert (rf_waddr === e.waddr) else begin
                n_err++;
                $error("FAIL %s rf_waddr observed %0h expected %0h", e.tag, rf_waddr, e.waddr);
            end
            n_checks++;
            assert (rf_wdata === e.wdata) else begin
                n_err++;
                $error("FAIL %s rf_wdata observed %0h expected %0h", e.tag, rf_wdata, e.wdata);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Pipeline (rd=5) and LLU (rd=7) both held for five cycles; with the
    // guard the bubble request appears on the fifth cycle (index 4).
    task automatic blocked_run(input string name);
        set_pipe(1'b1, 4'd5, 1'b0, 16'h1111, 16'h9999);
        set_lu(1'b1, 4'd7, 16'h00AA);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("%s_blk%0d", name, i), 1'b1, 4'd5, 16'h1111, 1'b0,
                 (i == 4) ? c_GUARD : 1'b0, 1'b1);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0;
        set_pipe(1'b1, 4'd3, 1'b1, 16'h1234, 16'hBEEF);
        set_lu(1'b1, 4'd2, 16'h2222);
        #1;
        step("reset", 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Pipeline only, memory data selected.
        set_lu(1'b0, 4'd0, 16'h0);
        step("pipe_only", 1'b1, 4'd3, 16'hBEEF, 1'b0, 1'b0, 1'b1);

        // Simultaneous requests, then the LLU on the next free cycle.
        set_pipe(1'b1, 4'd5, 1'b0, 16'h1111, 16'h9999);
        set_lu(1'b1, 4'd7, 16'h00AA);
        step("simul_pipe", 1'b1, 4'd5, 16'h1111, 1'b0, 1'b0, 1'b1);
        set_pipe(1'b0, 4'd5, 1'b0, 16'h1111, 16'h9999);
        step("simul_lu", 1'b1, 4'd7, 16'h00AA, 1'b1, 1'b0, 1'b1);

        // r0 pipeline write does not block the LLU.
        set_pipe(1'b1, 4'd0, 1'b0, 16'h5555, 16'h6666);
        set_lu(1'b1, 4'd2, 16'h2222);
        step("r0_pipe", 1'b1, 4'd2, 16'h2222, 1'b1, 1'b0, 1'b1);
        // LLU to r0 is consumed without a write.
        set_pipe(1'b0, 4'd0, 1'b0, 16'h5555, 16'h6666);
        set_lu(1'b1, 4'd0, 16'h3333);
        step("r0_lu", 1'b0, 4'd0, 16'h3333, 1'b1, 1'b0, 1'b1);

        set_lu(1'b0, 4'd0, 16'h0);
        step("idle", 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Starvation: bubble request, then the bubble serves the LLU.
        blocked_run("starve");
        set_pipe(1'b0, 4'd5, 1'b0, 16'h1111, 16'h9999);
        step("starve_grant", 1'b1, 4'd7, 16'h00AA, 1'b1, 1'b0, 1'b1);
        set_lu(1'b0, 4'd0, 16'h0);
        step("starve_idle", 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Contract violation: pipeline keeps writing during the grant.
        blocked_run("viol");
        step("viol_grant", 1'b1, 4'd5, 16'h1111, 1'b0, 1'b0, 1'b1);
        exp_perr = c_GUARD;
        step("viol_flag", 1'b1, 4'd5, 16'h1111, 1'b0, 1'b0, 1'b1);
        set_pipe(1'b0, 4'd0, 1'b0, 16'h0, 16'h0);
        set_lu(1'b0, 4'd0, 16'h0);
        for (int i = 0; i < 11; i++) begin
            step($sformatf("viol_sticky%0d", i), 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b1);
        end

        // Reset while in the forced grant, then a full fresh blocked episode.
        blocked_run("pre_rst");
        rst_n    = 1'b0;
        exp_perr = 1'b0;
        step("rst_grant", 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        blocked_run("post_rst");
        set_pipe(1'b0, 4'd5, 1'b0, 16'h1111, 16'h9999);
        step("post_rst_grant", 1'b1, 4'd7, 16'h00AA, 1'b1, 1'b0, 1'b1);
        set_lu(1'b0, 4'd0, 16'h0);
        step("post_rst_idle", 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
